// File: rtl/mem_arbiter.sv
// Datapath-facing memory arbiter: serializes I-fetch and D load/store
// requests onto a single-ported RAM and returns one-cycle hit pulses.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  input  logic        halt,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        mem_err
);

  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;
  logic          is_i_q, is_i_d;
  logic          is_wr_q, is_wr_d;
  logic          err_q, err_d;
  logic          wait_hit;

  assign wait_hit = (wait_q + CW'(1)) == CW'(TIMEOUT);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    store_d = store_q;
    iload_d = iload_q;
    dload_d = dload_q;
    is_i_d  = is_i_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (dmemREN | dmemWEN) begin
          state_d = DACC;
          addr_d  = dmemaddr;
          store_d = dmemstore;
          is_i_d  = 1'b0;
          is_wr_d = dmemWEN;
          wait_d  = '0;
        end else if (imemREN & ~halt) begin
          state_d = IACC;
          addr_d  = imemaddr;
          is_i_d  = 1'b1;
          is_wr_d = 1'b0;
          wait_d  = '0;
        end
      end
      IACC: begin
        // a withdrawn fetch is dropped even if the RAM answers now
        if (!imemREN) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          iload_d = ramload;
          state_d = RESP;
        end else if (wait_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      DACC: begin
        if (ram_ready) begin
          if (!is_wr_q) dload_d = ramload;
          state_d = RESP;
        end else if (wait_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      store_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
      is_i_q  <= 1'b0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      is_i_q  <= is_i_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
    end
  end

  // strobes decode straight from state so reset drops them at once
  assign ramREN   = (state_q == IACC) |
                    ((state_q == DACC) & ~is_wr_q);
  assign ramWEN   = (state_q == DACC) & is_wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = (state_q == RESP) & is_i_q;
  assign dhit     = (state_q == RESP) & ~is_i_q;
  assign imemload = iload_q;
  assign dmemload = dload_q;
  assign mem_err  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, waits, halt,
// timeout and mid-access reset.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic        dhit;
  logic [31:0] dmemload;
  logic        halt = 1'b0;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic        ram_ready = 1'b0;
  logic        mem_err;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload),
    .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    int rc;
    int k;
    #2;
    check("rst_ihit", ihit, 0);
    check("rst_dhit", dhit, 0);
    check("rst_ren", ramREN, 0);
    check("rst_wen", ramWEN, 0);
    check("rst_err", mem_err, 0);
    check("rst_iload", imemload, 0);
    check("rst_dload", dmemload, 0);
    check("rst_addr", ramaddr, 0);
    check("rst_store", ramstore, 0);
    step();
    nRST = 1'b1;

    // zero-wait fetch
    step();
    imemREN = 1; imemaddr = 32'h40;
    ram_ready = 1; ramload = 32'h8C010004;
    smp(); check("t1_c0_ren", ramREN, 0);
    step(); smp();
    check("t1_c1_ren", ramREN, 1);
    check("t1_c1_addr", ramaddr, 32'h40);
    check("t1_c1_ihit", ihit, 0);
    step(); smp();
    check("t1_c2_ihit", ihit, 1);
    check("t1_c2_iload", imemload, 32'h8C010004);
    check("t1_c2_ren", ramREN, 0);
    step();
    imemREN = 0; ram_ready = 0;
    smp(); check("t1_c3_ihit", ihit, 0);

    // contention: write first, two RAM waits
    step();
    imemREN = 1; imemaddr = 32'h44;
    dmemWEN = 1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
    step(); smp();
    check("t2_c1_wen", ramWEN, 1);
    check("t2_c1_ren", ramREN, 0);
    check("t2_c1_addr", ramaddr, 32'h100);
    check("t2_c1_store", ramstore, 32'hDEADBEEF);
    step(); smp();
    check("t2_c2_wen", ramWEN, 1);
    step();
    ram_ready = 1; ramload = 32'h0;
    smp();
    check("t2_c3_wen", ramWEN, 1);
    check("t2_c3_dhit", dhit, 0);
    step();
    ram_ready = 0;
    smp();
    check("t2_c4_dhit", dhit, 1);
    check("t2_c4_ihit", ihit, 0);
    check("t2_c4_wen", ramWEN, 0);
    step();
    dmemWEN = 0;
    smp(); check("t2_c5_ren", ramREN, 0);
    step();
    ram_ready = 1; ramload = 32'h11112222;
    smp();
    check("t2_c6_ren", ramREN, 1);
    check("t2_c6_addr", ramaddr, 32'h44);
    step();
    ram_ready = 0;
    smp();
    check("t2_c7_ihit", ihit, 1);
    check("t2_c7_iload", imemload, 32'h11112222);
    step();
    imemREN = 0;
    smp(); check("t2_c8_ihit", ihit, 0);

    // load with four wait cycles
    step();
    dmemREN = 1; dmemaddr = 32'h200; ramload = 32'hBADBAD00;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 5) begin
        ram_ready = 1; ramload = 32'h12345678;
      end else begin
        ram_ready = 0;
      end
      smp();
      check($sformatf("t3_c%0d_ihit", c), ihit, 0);
      if (c < 6) check($sformatf("t3_c%0d_dhit", c), dhit, 0);
      else begin
        check("t3_c6_dhit", dhit, 1);
        check("t3_c6_dload", dmemload, 32'h12345678);
      end
    end
    step();
    dmemREN = 0; ram_ready = 0;
    smp(); check("t3_c7_dhit", dhit, 0);

    // halt gates fetches, loads still served
    step();
    halt = 1; imemREN = 1; imemaddr = 32'h80;
    ram_ready = 1; ramload = 32'h0;
    rc = 0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (ramREN) rc++;
      step();
    end
    check("t4_halt_ren", rc, 0);
    dmemREN = 1; dmemaddr = 32'h300; ramload = 32'hCAFEF00D;
    k = 0;
    do begin
      smp();
      if (dhit) break;
      step();
      k++;
    end while (k < 10);
    check("t4_dhit", dhit, 1);
    check("t4_dload", dmemload, 32'hCAFEF00D);
    step();
    dmemREN = 0;
    rc = 0;
    for (int i = 0; i < 5; i++) begin
      smp();
      if (ramREN) rc++;
      step();
    end
    check("t4_post_ren", rc, 0);
    imemREN = 0; halt = 0; ram_ready = 0;

    // withdrawn fetch
    step();
    imemREN = 1; imemaddr = 32'h60;
    step();
    imemREN = 0;
    smp(); check("t5_c1_ren", ramREN, 1);
    step(); smp();
    check("t5_c2_ren", ramREN, 0);
    check("t5_c2_ihit", ihit, 0);
    step(); smp();
    check("t5_c3_ihit", ihit, 0);

    // timeout after eight wait cycles
    step();
    dmemREN = 1; dmemaddr = 32'h400;
    for (int c = 1; c <= 8; c++) begin
      step(); smp();
      check($sformatf("t6_c%0d_ren", c), ramREN, 1);
      check($sformatf("t6_c%0d_err", c), mem_err, 0);
    end
    step();
    dmemREN = 0;
    smp();
    check("t6_c9_err", mem_err, 1);
    check("t6_c9_ren", ramREN, 0);
    check("t6_c9_dhit", dhit, 0);
    step(); smp();
    check("t6_c10_dhit", dhit, 0);
    check("t6_c10_err", mem_err, 1);
    step();
    imemREN = 1; imemaddr = 32'h48;
    ram_ready = 1; ramload = 32'h00ABCDEF;
    k = 0;
    do begin
      smp();
      if (ihit) break;
      step();
      k++;
    end while (k < 10);
    check("t6_fetch_ihit", ihit, 1);
    check("t6_fetch_iload", imemload, 32'h00ABCDEF);
    check("t6_sticky_err", mem_err, 1);
    step();
    imemREN = 0; ram_ready = 0;
    nRST = 0;
    #1 check("t6_rst_err", mem_err, 0);
    step();
    nRST = 1;

    // reset in the middle of a write
    step();
    dmemWEN = 1; dmemaddr = 32'h500; dmemstore = 32'h55;
    step(); smp();
    check("t7_c1_wen", ramWEN, 1);
    #2 nRST = 0;
    #1;
    check("t7_rst_wen", ramWEN, 0);
    check("t7_rst_ren", ramREN, 0);
    dmemWEN = 0;
    step();
    nRST = 1;
    for (int i = 0; i < 4; i++) begin
      smp();
      check($sformatf("t7_post%0d_dhit", i), dhit, 0);
      check($sformatf("t7_post%0d_wen", i), ramWEN, 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
